// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the two-source Ethernet TX arbiter.
// Optional statistics counters are enabled with ETH_TX_ARB_STATS_EN.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int MAX_FRAME_LEN_DEF = 1518;
  localparam int MIN_FRAME_LEN     = 64;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// 8-bit AXI-Stream bundle used for both the source ports and the MAC port.
// Master drives data/valid/last, slave drives ready.
interface eth_tx_arbiter_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/eth_tx_arb_rr.sv
// Two-requester round-robin grant picker, purely combinational.
// On a tie the requester that was not granted last wins.
module eth_tx_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt_idx = ~last_grant;
      (req == 2'b10): gnt_idx = 1'b1;
      default:        gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the MAC TX stream between two
// sources, with length truncation; ETH_TX_ARB_STATS_EN adds frame counters.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF,
  parameter int CNT_W         = 16
) (
  input  logic                    tx_fifo_clk,
  input  logic                    tx_fifo_rstn,
  input  logic [1:0]              port_en,
  eth_tx_arbiter_if.slave         s0,
  eth_tx_arbiter_if.slave         s1,
  eth_tx_arbiter_if.master        m,
  output logic                    owner,
  output logic                    busy,
  output logic                    trunc_pulse,
  output logic [31:0]             frame_cnt0,
  output logic [31:0]             frame_cnt1,
  output logic [15:0]             trunc_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_FRAME_LEN - 1);

  if (MAX_FRAME_LEN < MIN_FRAME_LEN || MAX_FRAME_LEN > 65535 ||
      (64'd1 << CNT_W) <= 64'(MAX_FRAME_LEN)) begin : g_bad_cfg
    $error("eth_tx_arbiter: illegal MAX_FRAME_LEN/CNT_W");
  end

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             last_grant;
  logic             last_nxt;
  logic             owner_nxt;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             trunc_nxt;

  logic [1:0]       req;
  logic             gnt_valid;
  logic             gnt_idx;

  logic [7:0]       src_data;
  logic             src_valid;
  logic             src_last;
  logic             at_limit;
  logic             own_ready;
  logic             fwd;

  assign req = {s1.tvalid & port_en[1],
                s0.tvalid & port_en[0]};

  eth_tx_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign src_data  = owner ? s1.tdata  : s0.tdata;
  assign src_valid = owner ? s1.tvalid : s0.tvalid;
  assign src_last  = owner ? s1.tlast  : s0.tlast;
  assign at_limit  = (byte_cnt == LIMIT);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_grant;
    cnt_nxt   = byte_cnt;
    trunc_nxt = 1'b0;
    fwd       = 1'b0;
    own_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          owner_nxt = gnt_idx;
          last_nxt  = gnt_idx;
          cnt_nxt   = '0;
          state_nxt = PASS;
        end
      end
      PASS: begin
        fwd       = 1'b1;
        own_ready = m.tready;
        if (src_valid && m.tready) begin
          cnt_nxt = byte_cnt + CNT_W'(1);
          if (src_last) begin
            state_nxt = IDLE;
          end else if (at_limit) begin
            trunc_nxt = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Remainder of an over-long frame is swallowed here.
        own_ready = 1'b1;
        if (src_valid && src_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m.tdata  = fwd ? src_data : 8'h00;
  assign m.tvalid = fwd & src_valid;
  assign m.tlast  = fwd & (src_last | at_limit);

  assign s0.tready = own_ready & ~owner;
  assign s1.tready = own_ready & owner;

  assign busy = (state != IDLE);

  always_ff @(posedge tx_fifo_clk or negedge tx_fifo_rstn) begin
    if (!tx_fifo_rstn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      byte_cnt    <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_grant  <= last_nxt;
      byte_cnt    <= cnt_nxt;
      trunc_pulse <= trunc_nxt;
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic        done;
  logic [31:0] fc0_q;
  logic [31:0] fc1_q;
  logic [15:0] tc_q;

  assign done = (state == PASS  && src_valid && m.tready && src_last) ||
                (state == DRAIN && src_valid && src_last);

  always_ff @(posedge tx_fifo_clk or negedge tx_fifo_rstn) begin
    if (!tx_fifo_rstn) begin
      fc0_q <= '0;
      fc1_q <= '0;
      tc_q  <= '0;
    end else begin
      if (done && !owner) fc0_q <= fc0_q + 32'd1;
      if (done && owner)  fc1_q <= fc1_q + 32'd1;
      if (trunc_nxt)      tc_q  <= tc_q + 16'd1;
    end
  end

  assign frame_cnt0 = fc0_q;
  assign frame_cnt1 = fc1_q;
  assign trunc_cnt  = tc_q;
`else
  assign frame_cnt0 = 32'd0;
  assign frame_cnt1 = 32'd0;
  assign trunc_cnt  = 16'd0;
`endif

endmodule
